// File: rtl/lcd_spi_rx.sv
// SPI (mode 0) slave receiver for the LCD link: rebuilds DCX-tagged bytes from
// the CSX/SCK/SDO/DCX stream and queues them in a small FIFO for the reader.
module lcd_spi_rx #(
  parameter int DEPTH = 4,
  parameter bit SYNC  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     CSX,
  input  logic                     SCK,
  input  logic                     SDO,
  input  logic                     DCX,
  input  logic                     rd_en,
  input  logic                     clear,
  output logic [8:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LVL = (AW + 1)'(DEPTH);
  // Idle bus image {CSX, DCX, SCK, SDO}: deselected, data mode, clock low.
  localparam logic [3:0]       IDLE_BUS = 4'b1100;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [3:0] raw_bus;
  logic [3:0] cond_bus;
  logic       csx_c, dcx_c, sck_c, sdo_c;
  logic       sck_prev;
  logic       sck_rise;

  assign raw_bus = {CSX, DCX, SCK, SDO};

  generate
    if (SYNC) begin : g_sync
      logic [3:0] meta_bus;
      logic [3:0] stab_bus;

      // NOTE: clocked state is always assigned with <= so every flop samples
      // the pre-edge value of its neighbours; = here would collapse the chain.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_bus <= IDLE_BUS;
          stab_bus <= IDLE_BUS;
        end else begin
          meta_bus <= raw_bus;
          stab_bus <= meta_bus;
        end
      end

      assign cond_bus = stab_bus;
    end else begin : g_nosync
      logic [3:0] stab_bus;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) stab_bus <= IDLE_BUS;
        else       stab_bus <= raw_bus;
      end

      assign cond_bus = stab_bus;
    end
  endgenerate

  assign {csx_c, dcx_c, sck_c, sdo_c} = cond_bus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sck_prev <= 1'b0;
    else       sck_prev <= sck_c;
  end

  assign sck_rise = sck_c & ~sck_prev;
  assign busy     = ~csx_c;

  // ---------------------------------------------------------------------------
  // Bit capture
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic       byte_done;
  logic [8:0] byte_word;

  assign byte_done = sck_rise & ~csx_c & (bit_cnt == 3'd7);
  assign byte_word = {dcx_c, shift_q, sdo_c};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shift_q <= 7'd0;
    end else if (csx_c) begin
      // Deselect throws away any partial byte.
      bit_cnt <= 3'd0;
    end else if (sck_rise) begin
      shift_q <= {shift_q[5:0], sdo_c};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         frame_err <= 1'b0;
    else if (clear)                    frame_err <= 1'b0;
    else if (csx_c && bit_cnt != 3'd0) frame_err <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic          drop;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    drop    = 1'b0;
    if (!clear) begin
      pop_ok = rd_en && (level != '0);
      if (byte_done) begin
        if (level != FULL_LVL || pop_ok) push_ok = 1'b1;
        else                             drop    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; only pointers and level do, and the
  // head is masked below so nothing stale is visible while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= byte_word;
  end

  assign rd_valid = (level != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 9'h000;

endmodule

// File: doc/lcd_spi_rx.md
Name: lcd_spi_rx

Overview:
- SPI receiver (slave end) for the LCD link: captures the CSX/SCK/SDO/DCX stream produced by the LCD SPI transmitter and rebuilds the command/data bytes.
- Each byte is tagged with its DCX value and pushed into a small FIFO that the CPU-side logic or testbench pops with a read strobe.
- Used as an LCD stand-in for loopback testing and as a bus monitor on the display header.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC, 1, 1 = two-flop synchronizers on CSX/SCK/SDO/DCX (asynchronous source); 0 = single register stage (source clocked by the same clk).

Ports:
- clk  input  1  system clock (25 MHz).
- reset  input  1  asynchronous, active-high reset.
- CSX  input  1  SPI chip select, active low.
- SCK  input  1  SPI serial clock; idle low; data sampled on rising edge (mode 0).
- SDO  input  1  serial data from the transmitter, MSB first.
- DCX  input  1  data/command-not; sampled with the 8th bit of each byte.
- rd_en  input  1  pop the FIFO head; ignored when rd_valid = 0.
- clear  input  1  synchronous flush of the FIFO and both sticky flags.
- rd_data  output  9  FIFO head: {dcx, byte[7:0]}; valid only while rd_valid = 1.
- rd_valid  output  1  FIFO not empty.
- level  output  $clog2(DEPTH)+1  number of occupied entries.
- busy  output  1  synchronized CSX is low (frame in progress).
- overflow  output  1  sticky: a completed byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: CSX rose with a partial byte (1-7 bits) captured.

Behaviour:
- Reset (asynchronous) clears the synchronizers (SCK and SDO to 0, CSX and DCX to 1), bit counter, shift register, FIFO pointers and level. All outputs go to 0, with rd_data = 9'h000.
- Input conditioning:
  - SYNC = 1: each input passes through two flops, then a third flop on SCK gives the previous value.
  - SYNC = 0: one register stage plus the previous-value flop.
  - A rise is detected when the conditioned SCK = 1 and its previous value = 0.
- Timing constraints on the transmitter: SCK high and low phases must each be at least 2 clk cycles with SYNC = 1, or at least 1 clk cycle with SYNC = 0.
- Capture:
  - On each detected rise while conditioned CSX = 0: shift = {shift[6:0], SDO} and increment bit_cnt (3-bit).
  - On the rise where bit_cnt = 7: form {DCX, shift[6:0], SDO}, push it into the FIFO on the same clk edge, and wrap bit_cnt to 0.
  - The next byte starts without CSX toggling, so a 16-bit word arrives as two data bytes, MSB byte first.
- SCK rises are ignored while conditioned CSX = 1.
- When conditioned CSX goes high:
  - bit_cnt clears to 0 and any partial byte is discarded.
  - If bit_cnt was nonzero, frame_err is set.
- busy follows the conditioned, inverted CSX.
- Latency: rd_valid rises on the 3rd clk edge (SYNC = 1) or 2nd clk edge (SYNC = 0) after the first clk edge that samples the 8th SCK high.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - rd_data shows the head combinationally from the storage array.
  - A pop advances the read pointer on the rd_en edge.
- Full (level = DEPTH):
  - Push with no pop: the byte is dropped, overflow is set, and level stays at DEPTH.
  - Push and pop in the same cycle: both happen, level is unchanged, no overflow.
- Empty: rd_en is ignored and level stays 0. If a push and rd_en coincide while empty, the push is accepted and the pop is ignored (level becomes 1).
- clear:
  - Resets the pointers, level, overflow and frame_err on the next edge.
  - A byte completing in the same cycle is discarded.
  - clear does not affect the capture shift register or bit_cnt.
- Reset asserted mid-byte aborts the byte immediately. After release, capture restarts cleanly at the next CSX low or the next rise; no frame_err is set.

Test Plan:
- Single command byte: CSX low, DCX = 0, 8 bits of 0x2A, CSX high -> one entry 9'h02A, level = 1, frame_err = 0; rd_en -> rd_valid = 0.
- 16-bit data word: DCX = 1, 16 bits of 0xF81F under one CSX-low window -> entries 9'h1F8 then 9'h11F, in that order.
- Overflow, DEPTH = 4: send 5 bytes 0x01..0x05 with no reads -> level = 4, overflow = 1, reads return 0x01..0x04. Then clear -> overflow = 0, level = 0.
- Simultaneous push and pop at full: hold rd_en on the cycle the 5th byte completes -> no overflow, level stays 4, last read returns 0x05.
- Aborted frame: CSX high after 5 bits of 0xA5 -> no entry, frame_err = 1. A following full byte 0x3C is received correctly.
- Reset mid-byte: assert reset after 4 bits -> all outputs 0. Send 0x55 after release -> entry {DCX, 0x55}, frame_err = 0.
- Run all scenarios twice: SYNC = 0 with SCK half-period 1 clk, and SYNC = 1 with half-period 2 clk.
